sprite_linebuffer_scanout: RTL and testbench

- Display-side consumer of the sprite engine's linebuffer write port.
- Holds two 640x16 line buffers: a back buffer that the sprite engine writes, and a front buffer that is read out to the VGA pixel mux and cleared as it is read.
- Swaps the two buffers at the end of every scanline and issues the one-cycle sprite_start pulse that kicks the engine.
- Checks the engine's done flag at each swap and records any late line as an overrun.

---
 rtl/sprite_linebuffer_scanout.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_linebuffer_scanout.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_linebuffer_scanout.sv
// Double-buffered sprite linebuffer: engine fills the back line while the front line is scanned out and cleared.
// Define SPRITE_LB_STATS_EN to add the overrun_count and frame_lines statistics outputs.
module sprite_linebuffer_scanout #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_TOTAL     = 800,
   parameter logic [15:0] TRANSPARENT = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic [9:0]  sprite_pixel_col,
   input  logic [15:0] sprite_pixel_data,
   input  logic        wren_pixel_draw,
   input  logic        engine_done,
   output logic        sprite_start,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   output logic        overrun,
   output logic        init_busy
`ifdef SPRITE_LB_STATS_EN
   ,
   output logic [15:0] overrun_count,
   output logic [9:0]  frame_lines
`endif
);

   localparam int unsigned COL_W   = 10;
   localparam int unsigned PIX_W   = 16;
   localparam int unsigned IGN_W   = 2;
   localparam int unsigned STAT_W  = 16;
   localparam logic [COL_W-1:0] H_ACT_L    = COL_W'(H_ACTIVE);
   localparam logic [COL_W-1:0] INIT_LAST  = COL_W'(H_ACTIVE - 1);
   localparam logic [COL_W-1:0] H_LAST     = COL_W'(H_TOTAL - 1);
   localparam logic [COL_W-1:0] START_LIM  = COL_W'(479);
   localparam logic [COL_W-1:0] LAST_LINE  = COL_W'(524);
   localparam logic [IGN_W-1:0] IGN_CYCLES = IGN_W'(2);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_DRAWING,
      ST_DRAWN
   } state_e;

   state_e               state_q;
   logic [COL_W-1:0]     init_cnt_q;
   logic                 sel_q;
   logic [IGN_W-1:0]     ign_q;
   logic                 rd_act_q;
   logic                 rd_sel_q;
   logic [COL_W-1:0]     rd_addr_q;
   logic [PIX_W-1:0]     rd_data_q;
   logic                 sprite_start_q;
   logic [PIX_W-1:0]     pix_data_q;
   logic                 pix_valid_q;
   logic                 overrun_q;
   logic                 init_busy_q;

   logic [PIX_W-1:0]     lb_mem [2][H_ACTIVE];

   logic                 swap_c;
   logic                 start_c;
   logic                 active_c;
   logic                 ovr_evt_c;
   logic                 back_sel_c;
   logic                 we_c [2];
   logic [COL_W-1:0]     wa_c [2];
   logic [PIX_W-1:0]     wd_c [2];

   // Line-boundary events; a done seen in the swap cycle itself counts as on time.
   assign swap_c     = (state_q != ST_INIT) && (hcount == H_LAST);
   assign start_c    = swap_c && ((vcount < START_LIM) || (vcount == LAST_LINE));
   assign active_c   = (state_q != ST_INIT) && (hcount < H_ACT_L);
   assign ovr_evt_c  = swap_c && (state_q == ST_DRAWING) && !engine_done;
   assign back_sel_c = ~sel_q;

   // Per-buffer write port: init clear wins, then clear-behind, then engine writes.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         we_c[b] = 1'b0;
         wa_c[b] = '0;
         wd_c[b] = TRANSPARENT;
      end
      if (state_q == ST_INIT) begin
         for (int b = 0; b < 2; b++) begin
            we_c[b] = 1'b1;
            wa_c[b] = init_cnt_q;
         end
      end else begin
         if (wren_pixel_draw && (sprite_pixel_col < H_ACT_L)) begin
            we_c[back_sel_c] = 1'b1;
            wa_c[back_sel_c] = sprite_pixel_col;
            wd_c[back_sel_c] = sprite_pixel_data;
         end
         if (rd_act_q) begin
            we_c[rd_sel_q] = 1'b1;
            wa_c[rd_sel_q] = rd_addr_q;
            wd_c[rd_sel_q] = TRANSPARENT;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (we_c[b]) begin
            lb_mem[b][wa_c[b]] <= wd_c[b];
         end
      end
      if (active_c) begin
         rd_data_q <= lb_mem[sel_q][hcount];
      end
   end

   // Init sequencer, engine-tracking FSM, buffer swap and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_INIT;
         init_cnt_q     <= '0;
         sel_q          <= 1'b0;
         ign_q          <= '0;
         rd_act_q       <= 1'b0;
         rd_sel_q       <= 1'b0;
         rd_addr_q      <= '0;
         sprite_start_q <= 1'b0;
         pix_data_q     <= TRANSPARENT;
         pix_valid_q    <= 1'b0;
         overrun_q      <= 1'b0;
         init_busy_q    <= 1'b1;
      end else begin
         sprite_start_q <= start_c;
         rd_act_q       <= active_c;
         rd_sel_q       <= sel_q;
         rd_addr_q      <= hcount;
         pix_data_q     <= rd_act_q ? rd_data_q : TRANSPARENT;
         pix_valid_q    <= rd_act_q && (rd_data_q != TRANSPARENT);

         case (state_q)
            ST_INIT: begin
               if (init_cnt_q == INIT_LAST) begin
                  init_busy_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  init_cnt_q <= init_cnt_q + COL_W'(1);
               end
            end
            ST_DRAWING: begin
               if (ign_q != '0) begin
                  ign_q <= ign_q - IGN_W'(1);
               end else if (engine_done) begin
                  state_q <= ST_DRAWN;
               end
            end
            default: begin
            end
         endcase

         if (swap_c) begin
            sel_q <= ~sel_q;
            if (ovr_evt_c) begin
               overrun_q <= 1'b1;
            end
            if (start_c) begin
               state_q <= ST_DRAWING;
               ign_q   <= IGN_CYCLES;
            end else begin
               state_q <= ST_IDLE;
            end
         end
      end
   end

   assign sprite_start = sprite_start_q;
   assign pix_data     = pix_data_q;
   assign pix_valid    = pix_valid_q;
   assign overrun      = overrun_q;
   assign init_busy    = init_busy_q;

`ifdef SPRITE_LB_STATS_EN
   logic [STAT_W-1:0] ovr_cnt_q;
   logic [COL_W-1:0]  line_cnt_q;
   logic [COL_W-1:0]  frame_lines_q;

   // Saturating overrun counter and per-frame start count latched at the frame's last swap.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovr_cnt_q     <= '0;
         line_cnt_q    <= '0;
         frame_lines_q <= '0;
      end else begin
         if (ovr_evt_c && (ovr_cnt_q != '1)) begin
            ovr_cnt_q <= ovr_cnt_q + STAT_W'(1);
         end
         if (swap_c && (vcount == LAST_LINE)) begin
            frame_lines_q <= line_cnt_q + COL_W'(start_c);
            line_cnt_q    <= '0;
         end else if (start_c) begin
            line_cnt_q <= line_cnt_q + COL_W'(1);
         end
      end
   end

   assign overrun_count = ovr_cnt_q;
   assign frame_lines   = frame_lines_q;
`endif

endmodule

// File: tb/tb_sprite_linebuffer_scanout.sv
// Randomized bench for sprite_linebuffer_scanout, checked cycle by cycle against a line-level model.
// With SPRITE_LB_STATS_EN defined it also checks overrun_count and frame_lines.
module tb_sprite_linebuffer_scanout;

   localparam int H_ACTIVE  = 640;
   localparam int H_TOTAL   = 800;
   localparam int N_LINES   = 22;
   localparam int RST_LINE  = 14;
   localparam int MAX_CYC   = 40000;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [9:0]  sprite_pixel_col;
   logic [15:0] sprite_pixel_data;
   logic        wren_pixel_draw;
   logic        engine_done;
   logic        sprite_start;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        overrun;
   logic        init_busy;
`ifdef SPRITE_LB_STATS_EN
   logic [15:0] overrun_count;
   logic [9:0]  frame_lines;
`endif

   sprite_linebuffer_scanout dut (
      .clk               (clk),
      .reset             (reset),
      .hcount            (hcount),
      .vcount            (vcount),
      .sprite_pixel_col  (sprite_pixel_col),
      .sprite_pixel_data (sprite_pixel_data),
      .wren_pixel_draw   (wren_pixel_draw),
      .engine_done       (engine_done),
      .sprite_start      (sprite_start),
      .pix_data          (pix_data),
      .pix_valid         (pix_valid),
      .overrun           (overrun),
      .init_busy         (init_busy)
`ifdef SPRITE_LB_STATS_EN
      ,
      .overrun_count     (overrun_count),
      .frame_lines       (frame_lines)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: two whole-line images that trade places at each line end.
   logic [15:0] m_front [H_ACTIVE];
   logic [15:0] m_back  [H_ACTIVE];
   int          init_left;
   bit          pending;
   bit          done_seen;
   bit          m_ovr;
   int          m_ovr_cnt;
   int          m_line_cnt;
   int          m_frame_lines;
   int          edge_no;
   int          start_edge;
   logic [15:0] rd_pix;
   logic [15:0] exp_pix;
   bit          exp_val;
   bit          exp_start;
   bit          exp_busy;

   int checks;
   int failures;

   int cyc;
   int ln;
   int st_age;
   int mode;
   int done_at;
   int vtab [N_LINES];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d line=%0d: got 0x%0h expected 0x%0h", tag, edge_no, ln, got, exp);
      end
   endtask

   task automatic model_edge();
      logic [15:0] tmp;
      bit          start;
      if (reset) begin
         init_left     = H_ACTIVE;
         pending       = 0;
         done_seen     = 0;
         m_ovr         = 0;
         m_ovr_cnt     = 0;
         m_line_cnt    = 0;
         m_frame_lines = 0;
         for (int i = 0; i < H_ACTIVE; i++) begin
            m_front[i] = 16'h0000;
            m_back[i]  = 16'h0000;
         end
         rd_pix    = 16'h0000;
         exp_pix   = 16'h0000;
         exp_start = 0;
      end else begin
         exp_pix   = rd_pix;
         exp_start = 0;
         if (init_left > 0) begin
            init_left--;
            rd_pix = 16'h0000;
         end else begin
            if (wren_pixel_draw && int'(sprite_pixel_col) < H_ACTIVE)
               m_back[sprite_pixel_col] = sprite_pixel_data;
            if (int'(hcount) < H_ACTIVE) begin
               rd_pix = m_front[hcount];
               m_front[hcount] = 16'h0000;
            end else begin
               rd_pix = 16'h0000;
            end
            if (pending && engine_done && edge_no >= start_edge + 3)
               done_seen = 1;
            if (int'(hcount) == H_TOTAL - 1) begin
               if (pending && !done_seen) begin
                  m_ovr = 1;
                  if (m_ovr_cnt < 65535) m_ovr_cnt++;
               end
               for (int i = 0; i < H_ACTIVE; i++) begin
                  tmp        = m_front[i];
                  m_front[i] = m_back[i];
                  m_back[i]  = tmp;
               end
               start      = (vcount < 10'd479) || (vcount == 10'd524);
               exp_start  = start;
               pending    = start;
               done_seen  = 0;
               start_edge = edge_no;
               if (start) m_line_cnt++;
               if (vcount == 10'd524) begin
                  m_frame_lines = m_line_cnt;
                  m_line_cnt    = 0;
               end
            end
         end
      end
      exp_busy = (init_left > 0);
      exp_val  = (exp_pix != 16'h0000);
      edge_no++;
   endtask

   function automatic int pick_mode(input int line);
      case (line)
         1, 3:    return 0;
         2, 4:    return 1;
         5:       return 2;
         13:      return 1;
         default: begin
            int r;
            r = int'($urandom_range(0, 5));
            return (r == 0) ? 1 : ((r == 1) ? 2 : 0);
         end
      endcase
   endfunction

   // Timing generator plus a simple engine: done drops two cycles after a start, rises per mode.
   task automatic drive_next();
      if (sprite_start === 1'b1) begin
         st_age  = 0;
         mode    = pick_mode(ln);
         done_at = int'($urandom_range(10, 790));
      end else if (st_age >= 0) begin
         st_age++;
      end
      if (int'(hcount) == H_TOTAL - 1) begin
         hcount = 10'd0;
         ln++;
         vcount = 10'(vtab[ln % N_LINES]);
      end else begin
         hcount = hcount + 10'd1;
      end
      cyc++;
      reset = (cyc < 3) || (ln == RST_LINE && hcount >= 10'd300 && hcount <= 10'd303);
      if (reset) begin
         st_age      = -1;
         engine_done = 1'b0;
      end else begin
         if (st_age == 2) engine_done = 1'b0;
         if (st_age > 2 && mode == 0 && int'(hcount) == done_at) engine_done = 1'b1;
         if (st_age > 2 && mode == 2 && int'(hcount) == H_TOTAL - 1) engine_done = 1'b1;
      end
      wren_pixel_draw   = 1'b0;
      sprite_pixel_col  = 10'd0;
      sprite_pixel_data = 16'h0000;
      if (ln == 0 && hcount == 10'd700) begin
         wren_pixel_draw = 1'b1; sprite_pixel_col = 10'd5;   sprite_pixel_data = 16'hF800;
      end else if (ln == 0 && hcount == 10'd701) begin
         wren_pixel_draw = 1'b1; sprite_pixel_col = 10'd639; sprite_pixel_data = 16'h07E0;
      end else if (ln == 0 && hcount == 10'd702) begin
         wren_pixel_draw = 1'b1; sprite_pixel_col = 10'd700; sprite_pixel_data = 16'hFFFF;
      end else if (!reset && ln >= 3 && $urandom_range(0, 7) == 0) begin
         wren_pixel_draw   = 1'b1;
         sprite_pixel_col  = 10'($urandom_range(0, 767));
         sprite_pixel_data = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("init_busy",    32'(init_busy),    32'(exp_busy));
      check("sprite_start", 32'(sprite_start), 32'(exp_start));
      check("overrun",      32'(overrun),      32'(m_ovr));
      check("pix_data",     32'(pix_data),     32'(exp_pix));
      check("pix_valid",    32'(pix_valid),    32'(exp_val));
`ifdef SPRITE_LB_STATS_EN
      check("overrun_count", 32'(overrun_count), 32'(m_ovr_cnt));
      check("frame_lines",   32'(frame_lines),   32'(m_frame_lines));
`endif
      drive_next();
   endtask

   initial begin
      vtab = '{0, 1, 2, 3, 4, 477, 478, 479, 480, 523, 524,
               0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      checks      = 0;
      failures    = 0;
      edge_no     = 0;
      start_edge  = -100;
      init_left   = H_ACTIVE;
      rd_pix      = 16'h0000;
      cyc         = 0;
      ln          = 0;
      st_age      = -1;
      mode        = 0;
      done_at     = 0;
      reset             = 1'b1;
      hcount            = 10'd0;
      vcount            = 10'(vtab[0]);
      sprite_pixel_col  = 10'd0;
      sprite_pixel_data = 16'h0000;
      wren_pixel_draw   = 1'b0;
      engine_done       = 1'b0;
      while (ln < N_LINES && cyc < MAX_CYC) cycle();
      check("run_length", 32'(ln), 32'(N_LINES));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
